stm32_audio_scheduler: RTL



---
 rtl/audio_sched_pkg.sv | 30 +++
 rtl/audio_sample_fifo.sv | 65 ++++++
 rtl/stm32_audio_scheduler.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/audio_sched_pkg.sv
// audio_sched_pkg
//   Shared types and helpers for the STM32 -> codec audio scheduler.
//   mode_e     : output source selection (mute, STM32 stream, passthrough, mix)
//   state_e    : codec handshake sequencer states
//   stm_to_pcm : 12-bit offset-binary STM32 sample -> left-justified signed 32-bit PCM
//   CNT_W      : width of the saturating statistics counters
package audio_sched_pkg;

   localparam int CNT_W = 16;

   typedef enum logic [1:0] {
      MODE_MUTE = 2'b00,
      MODE_STM  = 2'b01,
      MODE_PASS = 2'b10,
      MODE_MIX  = 2'b11
   } mode_e;

   typedef enum logic [1:0] {
      ST_WAIT,
      ST_ISSUE,
      ST_GAP
   } state_e;

   // Mid-scale 0x800 is silence; flipping the MSB turns offset binary into
   // two's complement, then the sample is left-justified in the codec word.
   function automatic logic [31:0] stm_to_pcm(input logic [11:0] x);
      return {~x[11], x[10:0], 20'b0};
   endfunction

endpackage

// File: rtl/audio_sample_fifo.sv
// audio_sample_fifo
//   Synchronous first-word-fall-through FIFO for STM32 samples.
//   Ports:
//     CLOCK_50, reset : clock, async active-high reset
//     push, din       : write request and data (ignored when full unless popping)
//     pop             : consume head entry (ignored when empty)
//     flush           : empty the FIFO this cycle, overrides push/pop
//     dout            : head entry, valid while !empty
//     full, empty     : occupancy flags
//     level           : number of stored entries (0..DEPTH)
module audio_sample_fifo #(
   parameter int DEPTH = 16,
   parameter int WIDTH = 12
) (
   input  logic                     CLOCK_50,
   input  logic                     reset,
   input  logic                     push,
   input  logic                     pop,
   input  logic                     flush,
   input  logic [WIDTH-1:0]         din,
   output logic [WIDTH-1:0]         dout,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   level
);

   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign full  = (level == LW'(DEPTH));
   assign empty = (level == '0);
   assign dout  = mem[rd_ptr];

   // A push into a full FIFO is still accepted when the head leaves in the
   // same cycle; the write lands on the slot being vacated.
   assign do_pop  = pop  & ~flush & ~empty;
   assign do_push = push & ~flush & (~full | do_pop);

   always_ff @(posedge CLOCK_50 or posedge reset) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         level  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + AW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
         level <= level + LW'(do_push) - LW'(do_pop);
      end
   end

   always_ff @(posedge CLOCK_50) begin
      if (do_push) mem[wr_ptr] <= din;
   end

endmodule

// File: rtl/stm32_audio_scheduler.sv
// stm32_audio_scheduler
//   Buffers STM32 samples and paces the DE1 Audio_Controller FIFO handshake.
//   One output sample per codec tick (ADC available and DAC has room), with
//   the source chosen by mode_sel at that tick.
//   Ports:
//     CLOCK_50, reset                    : clock, async active-high reset
//     audio_in, audio_wr, audio_enable   : STM32 side (asynchronous, synchronised here)
//     audio_ready                        : backpressure to STM32
//     mode_sel                           : 00 mute, 01 STM32, 10 passthrough, 11 mix
//     audio_in_available, left/right_channel_audio_in, read_audio_in : codec ADC FIFO
//     audio_out_allowed, left/right_channel_audio_out, write_audio_out : codec DAC FIFO
//     fifo_level                         : STM32 FIFO occupancy
//     underrun_cnt, overrun_cnt          : saturating statistics
//   Build option: define AUDIO_SCHED_STATS_EN to implement the statistics
//   counters; otherwise they read as 0 and no counter flops are built.
//
//   state    | meaning
//   ST_WAIT  | idle, waiting for a codec tick; data/pop decided on the tick
//   ST_ISSUE | read_audio_in and write_audio_out strobed for one clock
//   ST_GAP   | one idle clock so Audio_Controller flags settle
module stm32_audio_scheduler
   import audio_sched_pkg::*;
#(
   parameter int SAMPLE_W     = 12,
   parameter int PCM_W        = 32,
   parameter int FIFO_DEPTH   = 16,
   parameter int READY_THRESH = 4
) (
   input  logic                          CLOCK_50,
   input  logic                          reset,
   input  logic [SAMPLE_W-1:0]           audio_in,
   input  logic                          audio_wr,
   input  logic                          audio_enable,
   output logic                          audio_ready,
   input  logic [1:0]                    mode_sel,
   input  logic                          audio_in_available,
   input  logic [PCM_W-1:0]              left_channel_audio_in,
   input  logic [PCM_W-1:0]              right_channel_audio_in,
   output logic                          read_audio_in,
   input  logic                          audio_out_allowed,
   output logic [PCM_W-1:0]              left_channel_audio_out,
   output logic [PCM_W-1:0]              right_channel_audio_out,
   output logic                          write_audio_out,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
   output logic [CNT_W-1:0]              underrun_cnt,
   output logic [CNT_W-1:0]              overrun_cnt
);

   logic                wr_s1, wr_s2, wr_d;
   logic                en_s1, en_s2;
   logic [SAMPLE_W-1:0] in_s1, in_s2;
   logic                push_q;

   // audio_in is held stable well past the WR rise, so by the time push_q
   // fires the synchronised bus carries the settled sample.
   always_ff @(posedge CLOCK_50 or posedge reset) begin
      if (reset) begin
         wr_s1  <= 1'b0;
         wr_s2  <= 1'b0;
         wr_d   <= 1'b0;
         en_s1  <= 1'b0;
         en_s2  <= 1'b0;
         in_s1  <= '0;
         in_s2  <= '0;
         push_q <= 1'b0;
      end else begin
         wr_s1  <= audio_wr;
         wr_s2  <= wr_s1;
         wr_d   <= wr_s2;
         en_s1  <= audio_enable;
         en_s2  <= en_s1;
         in_s1  <= audio_in;
         in_s2  <= in_s1;
         push_q <= wr_s2 & ~wr_d;
      end
   end

   logic                fifo_push, fifo_pop, fifo_full, fifo_empty;
   logic [SAMPLE_W-1:0] fifo_dout;

   audio_sample_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (SAMPLE_W)
   ) u_fifo (
      .CLOCK_50 (CLOCK_50),
      .reset    (reset),
      .push     (fifo_push),
      .pop      (fifo_pop),
      .flush    (~en_s2),
      .din      (in_s2),
      .dout     (fifo_dout),
      .full     (fifo_full),
      .empty    (fifo_empty),
      .level    (fifo_level)
   );

   state_e state, state_nxt;
   mode_e  mode;
   logic   tick, take, wants_stm;

   assign tick      = audio_in_available & audio_out_allowed;
   assign take      = (state == ST_WAIT) & tick;
   assign mode      = mode_e'(mode_sel);
   assign wants_stm = (mode == MODE_STM) | (mode == MODE_MIX);
   assign fifo_pop  = take & wants_stm & en_s2 & ~fifo_empty;
   assign fifo_push = push_q & en_s2 & (~fifo_full | fifo_pop);

   logic signed [PCM_W-1:0] stm_pcm, half_p, half_l, half_r;
   logic        [PCM_W-1:0] l_nxt, r_nxt;

   assign stm_pcm = (en_s2 & ~fifo_empty) ? stm_to_pcm(fifo_dout) : '0;
   assign half_p  = stm_pcm >>> 1;
   assign half_l  = $signed(left_channel_audio_in)  >>> 1;
   assign half_r  = $signed(right_channel_audio_in) >>> 1;

   always_comb begin
      l_nxt = '0;
      r_nxt = '0;
      case (mode)
         MODE_MUTE: begin
            l_nxt = '0;
            r_nxt = '0;
         end
         MODE_STM: begin
            l_nxt = stm_pcm;
            r_nxt = stm_pcm;
         end
         MODE_PASS: begin
            l_nxt = left_channel_audio_in;
            r_nxt = right_channel_audio_in;
         end
         MODE_MIX: begin
            l_nxt = half_l + half_p;
            r_nxt = half_r + half_p;
         end
         default: begin
            l_nxt = '0;
            r_nxt = '0;
         end
      endcase
   end

   always_ff @(posedge CLOCK_50 or posedge reset) begin
      if (reset) begin
         state                   <= ST_WAIT;
         left_channel_audio_out  <= '0;
         right_channel_audio_out <= '0;
         audio_ready             <= 1'b0;
      end else begin
         state       <= state_nxt;
         audio_ready <= en_s2 && ((FIFO_DEPTH - int'(fifo_level)) >= READY_THRESH);
         if (take) begin
            left_channel_audio_out  <= l_nxt;
            right_channel_audio_out <= r_nxt;
         end
      end
   end

   // Strobes decode straight from state so an async reset drops them at once.
   always_comb begin
      state_nxt       = state;
      read_audio_in   = 1'b0;
      write_audio_out = 1'b0;
      case (state)
         ST_WAIT:  if (tick) state_nxt = ST_ISSUE;
         ST_ISSUE: begin
            read_audio_in   = 1'b1;
            write_audio_out = 1'b1;
            state_nxt       = ST_GAP;
         end
         ST_GAP:   state_nxt = ST_WAIT;
         default:  state_nxt = ST_WAIT;
      endcase
   end

`ifdef AUDIO_SCHED_STATS_EN
   logic underrun, overrun;

   assign underrun = take & wants_stm & en_s2 & fifo_empty;
   assign overrun  = push_q & en_s2 & fifo_full & ~fifo_pop;

   always_ff @(posedge CLOCK_50 or posedge reset) begin
      if (reset) begin
         underrun_cnt <= '0;
         overrun_cnt  <= '0;
      end else begin
         if (underrun && underrun_cnt != '1) underrun_cnt <= underrun_cnt + CNT_W'(1);
         if (overrun  && overrun_cnt  != '1) overrun_cnt  <= overrun_cnt  + CNT_W'(1);
      end
   end
`else
   assign underrun_cnt = '0;
   assign overrun_cnt  = '0;
`endif

endmodule
